// File: rtl/nested_struct_rr_arbiter.sv
// Round-robin arbiter feeding one nested-struct transform datapath from NUM_REQ sources.
// Supports locked bursts (cmd[3]) and drops packets whose base.valid is clear.

package nested_struct_rr_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic [15:0] id;
        logic [3:0]  cmd;
        logic        ready;
    } base_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        base_t       base;
    } nested_struct_t;

endpackage

module nested_struct_rr_arbiter
    import nested_struct_rr_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned MAX_BURST = 4,
    parameter  int unsigned PKT_W     = 62,
    localparam int unsigned IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*PKT_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    output logic [PKT_W-1:0]         out_data,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         grant_idx,
    output logic                     locked,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned BURST_W = 4;
    localparam logic [BURST_W:0] BURST_LIM = (BURST_W+1)'(MAX_BURST);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    lock_state_e        state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               out_valid_q, out_valid_d;
    nested_struct_t     out_data_q, out_data_d;
    logic [7:0]         drop_q, drop_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   win_next;
    nested_struct_t     win_pkt;
    logic               can_accept;
    logic               accept;

    // Winner search: lock owner only, else first valid from rr_ptr upward.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        if (state_q == LOCKED) begin
            win_found = req_valid[grant_q];
            win_idx   = grant_q;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!win_found && req_valid[IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ)]) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
                end
            end
        end
    end

    assign win_pkt    = nested_struct_t'(req_data[32'(win_idx)*PKT_W +: PKT_W]);
    assign win_next   = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + IDX_W'(1);
    assign can_accept = !out_valid_q || out_ready;
    assign accept     = !rst && can_accept && win_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // Next-state: output slot, drop counter, round-robin pointer and burst lock.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        burst_d     = burst_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        drop_d      = drop_q;
        if (accept) begin
            if (!win_pkt.base.valid) begin
                rr_ptr_d = win_next;
                if (drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = win_pkt;
                grant_d     = win_idx;
                if (state_q == UNLOCKED) begin
                    if (win_pkt.base.cmd[3] && (MAX_BURST > 32'd1)) begin
                        state_d = LOCKED;
                        burst_d = BURST_W'(1);
                    end else begin
                        rr_ptr_d = win_next;
                    end
                end else if (win_pkt.base.cmd[3] &&
                             (({1'b0, burst_q} + (BURST_W+1)'(1)) < BURST_LIM)) begin
                    burst_d = burst_q + BURST_W'(1);
                end else begin
                    state_d  = UNLOCKED;
                    burst_d  = '0;
                    rr_ptr_d = win_next;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= UNLOCKED;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            burst_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            burst_q     <= burst_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            drop_q      <= drop_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = PKT_W'(out_data_q);
    assign grant_idx = grant_q;
    assign locked    = (state_q == LOCKED);
    assign drop_cnt  = drop_q;

endmodule
